// File: rtl/mux_scan_sequencer_if.sv
// Bus between the scan sequencer (master) and the mux/consumer side (slave).
// Word handshake: a transfer happens on every rising edge where word_valid and
// word_ready are both high; word_valid never falls without a transfer and word
// holds steady while valid unless a new scan completes on top of it.
interface mux_scan_sequencer_if;
  logic       start;
  logic       cont;
  logic       mux_out;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] word;
  logic       word_valid;
  logic       word_ready;
  logic       overrun;

  modport master (
    input  start, cont, mux_out, word_ready,
    output sel, busy, word, word_valid, overrun
  );

  modport slave (
    output start, cont, mux_out, word_ready,
    input  sel, busy, word, word_valid, overrun
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps the select of an external 8:1 mux, samples each channel after a settle
// delay and delivers the eight samples as one word over a valid/ready handshake.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  mux_scan_sequencer_if.master bus,
  output logic              o_dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_sel;
  logic [3:0] r_cnt;
  logic [6:0] r_shadow;
  logic [7:0] r_word;
  logic       r_word_valid;
  logic       r_overrun;

  logic       w_tick;
  logic       w_complete;
  logic       w_transfer;

  always_comb begin
    w_next_state = r_state;
    w_tick       = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next_state = ST_SCAN;
      end
      ST_SCAN: begin
        w_tick     = (r_cnt == 4'd0);
        w_complete = w_tick && (r_sel == 3'd7);
        if (w_complete && !bus.cont) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_transfer = r_word_valid & bus.word_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel        <= 3'd0;
      r_cnt        <= 4'd0;
      r_shadow     <= 7'd0;
      r_word       <= 8'h00;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (bus.start) begin
          r_sel <= 3'd0;
          r_cnt <= SETTLE;
        end
      end else if (!w_tick) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (!w_complete) begin
        for (int k = 0; k < 7; k++) begin
          if (r_sel == 3'(k)) r_shadow[k] <= bus.mux_out;
        end
        r_sel <= r_sel + 3'd1;
        r_cnt <= SETTLE;
      end else begin
        // Reload the counter even when returning to IDLE; it is unused there.
        r_sel <= 3'd0;
        r_cnt <= SETTLE;
      end

      if (w_complete) begin
        r_word       <= {bus.mux_out, r_shadow};
        r_word_valid <= 1'b1;
        if (r_word_valid && !bus.word_ready) r_overrun <= 1'b1;
      end else if (w_transfer) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign bus.sel        = r_sel;
  assign bus.busy       = (r_state == ST_SCAN);
  assign bus.word       = r_word;
  assign bus.word_valid = r_word_valid;
  assign bus.overrun    = r_overrun;
  assign o_dbg_state    = (r_state == ST_SCAN);

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (settle 2 and settle 0), each with
// a timing-rule reference model feeding an expected-word queue and a monitor.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       start [2];
  logic       cont  [2];
  logic       ready [2];
  logic [7:0] din   [2];

  logic [2:0] sel_o  [2];
  logic       busy_o [2];
  logic [7:0] word_o [2];
  logic       vld_o  [2];
  logic       ovr_o  [2];
  logic       dbg_o  [2];

  int n_tests = 0;
  int n_fail  = 0;

  mux_scan_sequencer_if bus_a ();
  mux_scan_sequencer_if bus_b ();

  assign bus_a.start      = start[0];
  assign bus_a.cont       = cont[0];
  assign bus_a.word_ready = ready[0];
  assign bus_a.mux_out    = din[0][bus_a.sel];
  assign bus_b.start      = start[1];
  assign bus_b.cont       = cont[1];
  assign bus_b.word_ready = ready[1];
  assign bus_b.mux_out    = din[1][bus_b.sel];

  assign sel_o[0] = bus_a.sel;   assign sel_o[1] = bus_b.sel;
  assign busy_o[0] = bus_a.busy; assign busy_o[1] = bus_b.busy;
  assign word_o[0] = bus_a.word; assign word_o[1] = bus_b.word;
  assign vld_o[0] = bus_a.word_valid; assign vld_o[1] = bus_b.word_valid;
  assign ovr_o[0] = bus_a.overrun;    assign ovr_o[1] = bus_b.overrun;

  mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .reset(rst[0]), .bus(bus_a.master), .o_dbg_state(dbg_o[0])
  );
  mux_scan_sequencer #(.SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst[1]), .bus(bus_b.master), .o_dbg_state(dbg_o[1])
  );

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got %0h expected %0h", name, g, act, exp);
    end
  endtask

  // Reference model: channel k of a scan starting at edge t0 is sampled at
  // t0+(k+1)(S+1); the eighth sample completes the word.
  for (genvar g = 0; g < 2; g++) begin : gen_model
    localparam int S = (g == 0) ? 2 : 0;
    logic [8:0] exp_q[$];
    int         t = 0;
    bit         active = 0;
    bit         pending = 0;
    bit         sticky = 0;
    logic [7:0] acc = 8'h00;
    logic [2:0] prev_sel = 3'd0;

    always @(posedge clk or posedge rst[g]) begin
      bit comp;
      int k;
      if (rst[g]) begin
        active = 0; pending = 0; sticky = 0; t = 0;
      end else begin
        comp = 0;
        if (!active) begin
          if (start[g]) begin active = 1; t = 0; end
        end else begin
          t++;
          if (t % (S + 1) == 0) begin
            k = t / (S + 1) - 1;
            acc[k] = din[g][k];
            if (k == 7) begin
              comp = 1;
              if (cont[g]) t = 0;
              else active = 0;
            end
          end
        end
        if (comp) begin
          if (pending && !ready[g]) sticky = 1;
          pending = 1;
          exp_q.push_back({sticky, acc});
        end else if (pending && ready[g]) begin
          pending = 0;
        end
      end
    end

    always @(negedge clk) begin
      logic [8:0] e;
      chk("busy", g, 32'(busy_o[g]), 32'(active));
      chk("dbg_state", g, 32'(dbg_o[g]), 32'(active));
      chk("sel", g, 32'(sel_o[g]), active ? 32'(t / (S + 1)) : 32'd0);
      chk("word_valid", g, 32'(vld_o[g]), 32'(pending));
      chk("overrun", g, 32'(ovr_o[g]), 32'(sticky));
      if (prev_sel == 3'd7 && sel_o[g] == 3'd0 && vld_o[g]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", g, 32'(word_o[g]), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", g, 32'(word_o[g]), 32'(e[7:0]));
          chk("sb_overrun", g, 32'(ovr_o[g]), 32'(e[8]));
        end
      end
      prev_sel = sel_o[g];
    end
  end

  task automatic wait_cmp(input int g);
    logic [2:0] p;
    p = sel_o[g];
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (p == 3'd7 && sel_o[g] == 3'd0) return;
      p = sel_o[g];
    end
    n_tests++; n_fail++;
    $display("FAIL timeout_completion[dut%0d]: got none expected completion", g);
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 300; i++) begin
      if (!busy_o[g]) return;
      @(negedge clk);
    end
    n_tests++; n_fail++;
    $display("FAIL timeout_idle[dut%0d]: got busy expected idle", g);
  endtask

  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] r;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; cont[g] = 1'b0; ready[g] = 1'b0; din[g] = 8'h00;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_sel", g, 32'(sel_o[g]), 0);
      chk("rst_word", g, 32'(word_o[g]), 0);
      chk("rst_busy", g, 32'(busy_o[g]), 0);
      chk("rst_vld", g, 32'(vld_o[g]), 0);
      chk("rst_ovr", g, 32'(ovr_o[g]), 0);
    end

    // Single shot, settle 2, A5.
    din[0] = 8'hA5;
    pulse_start(0);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_o[0]) n++;
      else if (n > 0) break;
      @(negedge clk);
    end
    chk("t1_busy_len", 0, 32'(n), 24);
    chk("t1_word", 0, 32'(word_o[0]), 32'hA5);
    chk("t1_vld", 0, 32'(vld_o[0]), 1);
    chk("t1_sel_idle", 0, 32'(sel_o[0]), 0);
    ready[0] = 1'b1;
    @(negedge clk);
    ready[0] = 1'b0;
    chk("t1_vld_drop", 0, 32'(vld_o[0]), 0);

    // Settle 0, 3C, consumer always ready.
    din[1] = 8'h3C; ready[1] = 1'b1;
    pulse_start(1);
    n = 1;
    while (!vld_o[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t2_latency", 1, 32'(n - 1), 8);
    chk("t2_word", 1, 32'(word_o[1]), 32'h3C);
    @(negedge clk);
    chk("t2_vld_one_cycle", 1, 32'(vld_o[1]), 0);

    // start held through a single-shot scan and into IDLE.
    ready[0] = 1'b1; din[0] = 8'($urandom_range(0, 255));
    start[0] = 1'b1;
    repeat (30) @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);
    chk("t6_idle_sel", 0, 32'(sel_o[0]), 0);
    repeat (2) @(negedge clk);

    // Continuous, consumer stalled, input changes mid second scan.
    ready[0] = 1'b0; cont[0] = 1'b1; din[0] = 8'h0F;
    pulse_start(0);
    wait_cmp(0);
    chk("t3_word1", 0, 32'(word_o[0]), 32'h0F);
    chk("t3_ovr1", 0, 32'(ovr_o[0]), 0);
    repeat (12) @(negedge clk);
    din[0] = 8'hF0;
    wait_cmp(0);
    chk("t3_word2", 0, 32'(word_o[0]), 32'hFF);
    chk("t3_ovr2", 0, 32'(ovr_o[0]), 1);
    cont[0] = 1'b0;
    wait_cmp(0);
    chk("t3_ovr_sticky", 0, 32'(ovr_o[0]), 1);
    ready[0] = 1'b1;
    wait_idle(0);
    @(negedge clk);

    // Continuous, settle 0, ready pulsed exactly on the second completion edge.
    ready[1] = 1'b0; cont[1] = 1'b1; din[1] = 8'($urandom_range(0, 255));
    pulse_start(1);
    wait_cmp(1);
    r = 8'($urandom_range(0, 255));
    din[1] = r;
    repeat (7) @(negedge clk);
    ready[1] = 1'b1;
    @(negedge clk);
    ready[1] = 1'b0;
    chk("t4_vld", 1, 32'(vld_o[1]), 1);
    chk("t4_word", 1, 32'(word_o[1]), 32'(r));
    chk("t4_ovr", 1, 32'(ovr_o[1]), 0);
    cont[1] = 1'b0; ready[1] = 1'b1;
    wait_idle(1);
    @(negedge clk);

    // Reset ten cycles into a scan.
    ready[0] = 1'b0; din[0] = 8'h5A;
    pulse_start(0);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 rst[0] = 1'b1;
    #1;
    chk("t5_sel", 0, 32'(sel_o[0]), 0);
    chk("t5_busy", 0, 32'(busy_o[0]), 0);
    chk("t5_vld", 0, 32'(vld_o[0]), 0);
    chk("t5_word", 0, 32'(word_o[0]), 0);
    chk("t5_ovr", 0, 32'(ovr_o[0]), 0);
    @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    r = 8'($urandom_range(0, 255));
    din[0] = r;
    pulse_start(0);
    wait_cmp(0);
    chk("t5_after_word", 0, 32'(word_o[0]), 32'(r));
    ready[0] = 1'b1;
    @(negedge clk);

    // Randomized traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      for (int g = 0; g < 2; g++) begin
        start[g] = ($urandom_range(0, 3) == 0);
        ready[g] = $urandom_range(0, 1);
        if ($urandom_range(0, 15) == 0) cont[g] = $urandom_range(0, 1);
        if ($urandom_range(0, 5) == 0) din[g] = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; cont[g] = 1'b0; ready[g] = 1'b1;
    end
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    chk("queue_empty", 0, 32'(gen_model[0].exp_q.size()), 0);
    chk("queue_empty", 1, 32'(gen_model[1].exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Sequential scan controller that pairs with the 8:1 single-bit multiplexers in this block family. It drives the 3-bit select of a downstream 8:1 mux and samples the mux output once per channel, after a programmable settle time. The eight samples are assembled into one 8-bit word and delivered over a valid/ready handshake. It supports single-shot scans and continuous back-to-back scans with sticky overrun detection.

## Interface
- SETTLE_CYCLES, default 2: idle cycles after each select change before the sample; legal range 0..15; counter width 4 bits.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request a scan; sampled only in IDLE.
- cont  in  1  continuous mode; sampled at each scan completion.
- mux_out  in  1  output of the 8:1 mux being scanned.
- sel  out  3  select driven to the mux; registered.
- busy  out  1  high while in SCAN.
- word  out  8  last completed scan; word[k] is the sample of channel k.
- word_valid  out  1  word holds unaccepted data.
- word_ready  in  1  consumer accepts word.
- overrun  out  1  sticky; an unaccepted word was overwritten.

## Operation
- Reset values: state IDLE, sel=0, cnt=0, shadow=0, word=8'h00, word_valid=0, busy=0, overrun=0.
- States: IDLE, SCAN. busy = (state==SCAN).
- IDLE, start=1:
  - Go to SCAN.
  - sel <= 0, cnt <= SETTLE_CYCLES.
- IDLE, start=0: hold; sel stays 0.
- SCAN, cnt!=0: cnt <= cnt-1; sel holds.
- SCAN, cnt==0 and sel!=7:
  - shadow[sel] <= mux_out.
  - sel <= sel+1, cnt <= SETTLE_CYCLES.
- SCAN, cnt==0 and sel==7 (completion edge):
  - word <= {mux_out, shadow[6:0]}, word_valid <= 1.
  - sel <= 0.
  - If cont=1: stay in SCAN, cnt <= SETTLE_CYCLES.
  - If cont=0: go to IDLE.
- start is ignored while busy. Deasserting cont mid-scan lets the current scan finish, then returns to IDLE.
- Handshake: transfer on any edge with word_valid & word_ready.
  - word_valid <= 0 unless a completion occurs on the same edge.
  - word_valid never drops without a transfer.
  - word is stable while word_valid=1 and no completion occurs.
- Completion while word_valid=1 and word_ready=0:
  - word overwritten with the new scan, word_valid stays 1.
  - overrun <= 1; overrun clears only on reset.
- Completion on the same edge as a transfer: new word loaded, word_valid stays 1, no overrun.
- Reset mid-scan aborts immediately. Partial shadow is discarded and no word is produced.

## Timing
- Let S = SETTLE_CYCLES, t0 = the edge on which start is accepted in IDLE.
- Each channel occupies S+1 cycles. Channel k is sampled at edge t0+(k+1)(S+1), using the mux_out value settled before that edge.
- Completion at edge t0+8(S+1); word_valid is high in the following cycle. For S=2 this is 24 cycles; for S=0 it is 8 cycles.
- With cont=1, the next scan's channel 0 is sampled at completion+(S+1). There are no dead cycles between scans.
- The mux is combinational, so S ≥ 0 is safe in RTL simulation. S sets the margin for gate-delay models.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Bench wires a behavioural 8:1 mux with I=8'hA5, S=2, cont=0. Pulse start -> busy high for 24 cycles, sel steps 0..7 every 3 cycles, word=8'hA5 with word_valid=1, then IDLE with sel=0.
- S=0, I=8'h3C, word_ready held 1 -> word=8'h3C valid for exactly one cycle, 8 cycles after start.
- cont=1, word_ready=0, I changed from 8'h0F to 8'hF0 mid-way through the second scan. Required response:
  - First completion: word=8'h0F, overrun=0.
  - Second completion: word = the mixed sample, overrun=1 and sticky.
- cont=1 with word_ready pulsed exactly on a completion edge -> word_valid stays 1 with the new word, overrun stays 0.
- Assert reset at cycle 10 of a scan -> in the same cycle sel=0, busy=0, word_valid=0, word=8'h00. A subsequent start completes normally with the correct word.
- start asserted continuously during a single-shot scan -> no restart, sel sequence unaffected. start still high in IDLE -> next scan begins on that edge.
